hazard_scoreboard: RTL

//  Parametrised register scoreboard for the pipelined CPU: tracks in-flight writes per register with

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_busy_counter.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types, defaults and decode opcodes for the hazard scoreboard.
// Optional ALU forwarding in the top is enabled with `HAZARD_FWD_EN.
package hazard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int LAT_LOAD_DEF = 2;
  localparam int RW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int CW_DEF       = $clog2(LAT_LOAD_DEF + 1);

  typedef logic [RW_DEF-1:0] reg_idx_t;
  typedef logic [CW_DEF-1:0] lat_t;

  typedef enum logic [5:0] {
    RI   = 6'h00,
    JUMP = 6'h02,
    BEQ  = 6'h04,
    ADDI = 6'h08,
    MUL  = 6'h1c,
    LW   = 6'h23,
    SW   = 6'h2b
  } opcode_e;

  // Counter width able to hold the longest write-back latency.
  function automatic int cnt_width(input int lat_load);
    return $clog2(lat_load + 1);
  endfunction

endpackage

// File: rtl/hazard_busy_counter.sv
// Per-register in-flight write timer: a new load beats the decrement,
// and the count saturates at zero.
module hazard_busy_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          load_is_ld,
  output logic [CW-1:0] cnt,
  output logic          ld
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (load) begin
      cnt_d = load_val;
      ld_d  = load_is_ld;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt = cnt_q;
  assign ld  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard gating decode->execute issue on RAW and WAW hazards.
// Define HAZARD_FWD_EN to let sources one cycle from an ALU write-back bypass.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0]  issue_src,
  input  logic [NUM_SRC-1:0]                   issue_src_use,
  input  logic [$clog2(NUM_REGS)-1:0]          issue_rd,
  input  logic                                 issue_rd_we,
  input  logic                                 issue_is_load,
  input  logic                                 flush,
  output logic                                 stall,
  output logic                                 issue_fire,
  output logic [NUM_SRC-1:0]                   fwd_hit,
  output logic [NUM_REGS-1:0]                  busy_vec
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = cnt_width(LAT_LOAD);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  if (!(LAT_LOAD >= LAT_ALU && LAT_ALU >= 1)) begin : g_bad_lat
    $error("hazard_scoreboard: need LAT_LOAD >= LAT_ALU >= 1");
  end

  logic [CW-1:0] cnt_arr [NUM_REGS];
  logic          ld_arr  [NUM_REGS];
  logic [CW-1:0] new_lat;
  logic          wr_en;
  logic          raw_any;
  logic          waw;

  assign new_lat = issue_is_load ? CW'(LAT_LOAD) : CW'(LAT_ALU);
  assign wr_en   = issue_fire & issue_rd_we & (issue_rd != '0);

  // Register 0 is hardwired zero and never tracked.
  assign cnt_arr[0] = '0;
  assign ld_arr[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      hazard_busy_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (wr_en && (issue_rd == RW'(gi))),
        .load_val   (new_lat),
        .load_is_ld (issue_is_load),
        .cnt        (cnt_arr[gi]),
        .ld         (ld_arr[gi])
      );
    end
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_vec[gi] = (cnt_arr[gi] != '0);
    end
  endgenerate

  always_comb begin
    raw_any = 1'b0;
    fwd_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [RW-1:0] src;
      logic          fwd_ok;
      src    = issue_src[i*RW +: RW];
      fwd_ok = FWD_EN && (cnt_arr[src] == CW'(1)) && !ld_arr[src];
      if (issue_src_use[i] && (src != '0) && (cnt_arr[src] != '0)) begin
        if (fwd_ok) fwd_hit[i] = 1'b1;
        else        raw_any    = 1'b1;
      end
    end
  end

  // A younger write must not land before an older, slower one to the same register.
  assign waw        = issue_rd_we && (issue_rd != '0) && (cnt_arr[issue_rd] > new_lat);
  assign stall      = issue_valid & (raw_any | waw);
  assign issue_fire = issue_valid & ~stall & ~flush;

endmodule
